// File: rtl/segment_scan_encoder.sv
// rtl/segment_scan_encoder.sv - Scanned seven-segment receiver that rebuilds digit codes and point flags per frame
//
// Purpose:
//   Samples the time-multiplexed, active-low segment/anode lines of a scanned
//   display, waits for each digit's pattern to be stable, decodes it back to a
//   4-bit code plus point flag and publishes a complete frame of digits.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digit positions (1..8)
//   STABLE_CYCLES  consecutive identical samples required before capture (>=1)
//   CNT_W          stability counter width, must hold STABLE_CYCLES
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg         active-low segments, [7:1] = a..g, [0] = dp
//   anode       active-low digit enables, one low bit selects a digit
//   digits      codes of the last complete frame, digit i at [4i+3:4i]
//   points      point flags of the last complete frame, 1 = dp lit
//   frameValid  one-cycle pulse when digits/points update
//   codeError   last complete frame held an unrecognised pattern
//   anodeError  sticky flag for a sample with two or more anodes low
//
// Build option:
//   SEG_INPUT_SYNC_EN  adds a 2-flop synchroniser on seg/anode ahead of the
//                      sample stage for an asynchronous display source.

module segment_scan_encoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   anode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   points,
    output logic                    frameValid,
    output logic                    codeError,
    output logic                    anodeError
);

    localparam int             IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
    // With a single-sample requirement the capture happens on the entry sample
    localparam logic           INSTANT  = (STABLE_CYCLES <= 1);

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic [7:0]            w_seg_in;
    logic [NUM_DIGITS-1:0] w_anode_in;

`ifdef SEG_INPUT_SYNC_EN
    logic [7:0]            r_seg_m1;
    logic [7:0]            r_seg_m2;
    logic [NUM_DIGITS-1:0] r_anode_m1;
    logic [NUM_DIGITS-1:0] r_anode_m2;

    // Reset to all-high so the idle display reads as blank/no digit selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m1   <= '1;
            r_seg_m2   <= '1;
            r_anode_m1 <= '1;
            r_anode_m2 <= '1;
        end else begin
            r_seg_m1   <= seg;
            r_seg_m2   <= r_seg_m1;
            r_anode_m1 <= anode;
            r_anode_m2 <= r_anode_m1;
        end
    end

    assign w_seg_in   = r_seg_m2;
    assign w_anode_in = r_anode_m2;
`else
    assign w_seg_in   = seg;
    assign w_anode_in = anode;
`endif

    // ------------------------------------------------------------------
    // Sample stage: current and previous registered sample
    // ------------------------------------------------------------------
    logic [7:0]            r_seg_s;
    logic [7:0]            r_seg_p;
    logic [NUM_DIGITS-1:0] r_anode_s;
    logic [NUM_DIGITS-1:0] r_anode_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s   <= '1;
            r_seg_p   <= '1;
            r_anode_s <= '1;
            r_anode_p <= '1;
        end else begin
            r_seg_s   <= w_seg_in;
            r_seg_p   <= r_seg_s;
            r_anode_s <= w_anode_in;
            r_anode_p <= r_anode_s;
        end
    end

    // ------------------------------------------------------------------
    // Anode classification
    // ------------------------------------------------------------------
    logic [3:0]       w_low_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_one_hot;
    logic             w_anode_invalid;
    logic             w_anode_chg;
    logic             w_same;

    always_comb begin
        w_low_cnt = 4'd0;
        w_idx     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!r_anode_s[k]) begin
                w_low_cnt = w_low_cnt + 4'd1;
                w_idx     = IDX_W'(k);
            end
        end
    end

    assign w_one_hot       = (w_low_cnt == 4'd1);
    assign w_anode_invalid = (w_low_cnt > 4'd1);
    assign w_anode_chg     = (r_anode_s != r_anode_p);
    assign w_same          = !w_anode_chg && (r_seg_s == r_seg_p);

    // ------------------------------------------------------------------
    // Segment pattern decode
    // ------------------------------------------------------------------
    logic [3:0] w_code;
    logic       w_bad;
    logic       w_point;

    always_comb begin
        w_code = 4'hF;
        w_bad  = 1'b0;
        case (r_seg_s[7:1])
            7'b0000001: w_code = 4'h0;
            7'b1001111: w_code = 4'h1;
            7'b0010010: w_code = 4'h2;
            7'b0000110: w_code = 4'h3;
            7'b1001100: w_code = 4'h4;
            7'b0100100: w_code = 4'h5;
            7'b0100000: w_code = 4'h6;
            7'b0001111: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0000100: w_code = 4'h9;
            7'b1111110: w_code = 4'hA;
            7'b1111111: w_code = 4'hF;
            default: begin
                w_code = 4'hF;
                w_bad  = 1'b1;
            end
        endcase
    end

    // Point is read straight off dp, whatever the segment pattern
    assign w_point = ~r_seg_s[0];

    // ------------------------------------------------------------------
    // Dwell decisions
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_enter;
    logic             w_capture;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // w_enter: a new one-hot dwell starts on this sample (counter := 1).
    // HOLD re-evaluates a changed anode exactly like SCAN in the same cycle,
    // so back-to-back digits lose no samples.
    always_comb begin
        w_enter   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_SCAN:   w_enter = w_one_hot;
            ST_SETTLE: begin
                if (w_same && w_one_hot) begin
                    w_capture = (w_cnt_inc >= STABLE_C);
                end else begin
                    w_enter = w_one_hot;
                end
            end
            ST_HOLD:   w_enter = w_anode_chg && w_one_hot;
            default:   w_enter = 1'b0;
        endcase
        if (w_enter && INSTANT) begin
            w_capture = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM, shadow frame buffer and registered outputs
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_sh_code;
    logic [NUM_DIGITS-1:0]   r_sh_pt;
    logic [NUM_DIGITS-1:0]   r_bad;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_points;
    logic                    r_frame_valid;
    logic                    r_code_err;
    logic                    r_anode_err;
    logic                    w_mask_full;

    assign w_mask_full = &r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SCAN;
            r_cnt         <= '0;
            r_sh_code     <= '0;
            r_sh_pt       <= '0;
            r_bad         <= '0;
            r_mask        <= '0;
            r_digits      <= '1;
            r_points      <= '0;
            r_frame_valid <= 1'b0;
            r_code_err    <= 1'b0;
            r_anode_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_state <= ST_HOLD;
            end else if (w_enter) begin
                r_state <= ST_SETTLE;
                r_cnt   <= CNT_W'(1);
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (w_same && w_one_hot) begin
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        if (w_anode_chg) begin
                            r_state <= ST_SCAN;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end

            // Publish the frame one cycle after the last slot fills.
            r_frame_valid <= w_mask_full;
            if (w_mask_full) begin
                r_digits   <= r_sh_code;
                r_points   <= r_sh_pt;
                r_code_err <= |r_bad;
                r_mask     <= '0;
                r_bad      <= '0;
            end

            // Placed after the frame clear so a capture in the publish cycle
            // survives as the first slot of the next frame.
            if (w_capture) begin
                r_sh_code[{w_idx, 2'b00} +: 4] <= w_code;
                r_sh_pt[w_idx]                 <= w_point;
                r_bad[w_idx]                   <= w_bad;
                r_mask[w_idx]                  <= 1'b1;
            end

            if (w_anode_invalid) begin
                r_anode_err <= 1'b1;
            end
        end
    end

    assign digits     = r_digits;
    assign points     = r_points;
    assign frameValid = r_frame_valid;
    assign codeError  = r_code_err;
    assign anodeError = r_anode_err;

endmodule

// File: tb/tb_segment_scan_encoder.sv
// tb/tb_segment_scan_encoder.sv - Directed self-checking bench for segment_scan_encoder

module tb_segment_scan_encoder;

`ifdef SEG_INPUT_SYNC_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  anode = 4'hF;
    logic [15:0] digits;
    logic [3:0]  points;
    logic        frameValid;
    logic        codeError;
    logic        anodeError;

    int vectors     = 0;
    int miscompares = 0;
    int fv_count    = 0;

    segment_scan_encoder #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .anode     (anode),
        .digits    (digits),
        .points    (points),
        .frameValid(frameValid),
        .codeError (codeError),
        .anodeError(anodeError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (frameValid === 1'b1) fv_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] sv(input int d, input bit dp);
        return {pat(d), ~dp};
    endfunction

    task automatic drive_digit(input int idx, input logic [7:0] s, input int cyc);
        logic [3:0] a;
        a = 4'hF;
        if (idx >= 0) a[idx] = 1'b0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            seg   = s;
            anode = a;
        end
    endtask

    task automatic blank(input int cyc);
        drive_digit(-1, 8'hFF, cyc);
    endtask

    task automatic scan_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        drive_digit(0, s0, 6);
        drive_digit(1, s1, 6);
        drive_digit(2, s2, 6);
        drive_digit(3, s3, 6);
        blank(4);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (digits !== 16'hFFFF) begin miscompares++; $display("FAIL reset_digits: got %h expected %h", digits, 16'hFFFF); end
        vectors++; if (points !== 4'h0) begin miscompares++; $display("FAIL reset_points: got %b expected %b", points, 4'h0); end
        vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL reset_frameValid: got %b expected 0", frameValid); end
        vectors++; if (codeError !== 1'b0) begin miscompares++; $display("FAIL reset_codeError: got %b expected 0", codeError); end
        vectors++; if (anodeError !== 1'b0) begin miscompares++; $display("FAIL reset_anodeError: got %b expected 0", anodeError); end
        rst_n = 1'b1;
        blank(3);
    endtask

    task automatic test_basic_frame;
        int f0;
        f0 = fv_count;
        scan_frame(8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101);
        vectors++; if (fv_count - f0 !== 1) begin miscompares++; $display("FAIL basic_pulses: got %0d expected 1", fv_count - f0); end
        vectors++; if (digits !== 16'h3210) begin miscompares++; $display("FAIL basic_digits: got %h expected %h", digits, 16'h3210); end
        vectors++; if (points !== 4'b0000) begin miscompares++; $display("FAIL basic_points: got %b expected 0000", points); end
        vectors++; if (codeError !== 1'b0) begin miscompares++; $display("FAIL basic_codeError: got %b expected 0", codeError); end
        vectors++; if (anodeError !== 1'b0) begin miscompares++; $display("FAIL basic_blank_gap_anodeError: got %b expected 0", anodeError); end
    endtask

    task automatic test_dash_point;
        scan_frame(sv(0, 0), sv(1, 0), 8'b11111100, sv(3, 0));
        vectors++; if (digits !== 16'h3A10) begin miscompares++; $display("FAIL dash_digits: got %h expected %h", digits, 16'h3A10); end
        vectors++; if (points !== 4'b0100) begin miscompares++; $display("FAIL dash_points: got %b expected 0100", points); end
    endtask

    task automatic test_short_dwell;
        int f0;
        f0 = fv_count;
        drive_digit(0, sv(5, 0), 6);
        drive_digit(1, sv(7, 0), 3);
        drive_digit(2, sv(8, 0), 6);
        drive_digit(3, sv(9, 0), 6);
        blank(4);
        vectors++; if (fv_count - f0 !== 0) begin miscompares++; $display("FAIL short_no_frame: got %0d pulses expected 0", fv_count - f0); end
        vectors++; if (digits !== 16'h3A10) begin miscompares++; $display("FAIL short_hold_digits: got %h expected %h", digits, 16'h3A10); end
        drive_digit(1, sv(4, 0), 6);
        blank(4);
        vectors++; if (fv_count - f0 !== 1) begin miscompares++; $display("FAIL short_rescan_frame: got %0d pulses expected 1", fv_count - f0); end
        vectors++; if (digits !== 16'h9845) begin miscompares++; $display("FAIL short_rescan_digits: got %h expected %h", digits, 16'h9845); end
        vectors++; if (points !== 4'b0000) begin miscompares++; $display("FAIL short_rescan_points: got %b expected 0000", points); end
    endtask

    task automatic test_bad_code;
        scan_frame(8'b01010101, sv(1, 0), sv(2, 0), sv(3, 0));
        vectors++; if (digits !== 16'h321F) begin miscompares++; $display("FAIL bad_digits: got %h expected %h", digits, 16'h321F); end
        vectors++; if (codeError !== 1'b1) begin miscompares++; $display("FAIL bad_codeError: got %b expected 1", codeError); end
        vectors++; if (points !== 4'b0000) begin miscompares++; $display("FAIL bad_points: got %b expected 0000", points); end
        scan_frame(sv(0, 0), sv(1, 0), sv(2, 0), sv(3, 0));
        vectors++; if (codeError !== 1'b0) begin miscompares++; $display("FAIL clean_codeError: got %b expected 0", codeError); end
        vectors++; if (digits !== 16'h3210) begin miscompares++; $display("FAIL clean_digits: got %h expected %h", digits, 16'h3210); end
    endtask

    task automatic test_min_dwell;
        int f0;
        f0 = fv_count;
        drive_digit(0, sv(6, 1), 4);
        drive_digit(1, sv(6, 0), 4);
        drive_digit(2, sv(15, 0), 4);
        drive_digit(3, sv(10, 0), 4);
        blank(4);
        vectors++; if (fv_count - f0 !== 1) begin miscompares++; $display("FAIL min_dwell_frame: got %0d pulses expected 1", fv_count - f0); end
        vectors++; if (digits !== 16'hAF66) begin miscompares++; $display("FAIL min_dwell_digits: got %h expected %h", digits, 16'hAF66); end
        vectors++; if (points !== 4'b0001) begin miscompares++; $display("FAIL min_dwell_points: got %b expected 0001", points); end
        vectors++; if (codeError !== 1'b0) begin miscompares++; $display("FAIL min_dwell_blank_ok: got %b expected 0", codeError); end
    endtask

    task automatic test_latency;
        int lat;
        drive_digit(0, sv(1, 0), 6);
        drive_digit(1, sv(2, 0), 6);
        drive_digit(2, sv(3, 0), 6);
        @(negedge clk);
        seg   = sv(4, 0);
        anode = 4'b0111;
        lat   = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #2;
            if (frameValid === 1'b1) break;
        end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL latency: got %0d cycles expected %0d", lat, LAT); end
        blank(4);
        vectors++; if (digits !== 16'h4321) begin miscompares++; $display("FAIL latency_digits: got %h expected %h", digits, 16'h4321); end
    endtask

    task automatic test_anode_error;
        int f0;
        f0 = fv_count;
        vectors++; if (anodeError !== 1'b0) begin miscompares++; $display("FAIL anode_pre: got %b expected 0", anodeError); end
        drive_digit(1, sv(1, 0), 6);
        drive_digit(2, sv(2, 0), 6);
        drive_digit(3, sv(3, 0), 6);
        @(negedge clk);
        seg   = sv(8, 0);
        anode = 4'b1100;
        blank(8);
        vectors++; if (anodeError !== 1'b1) begin miscompares++; $display("FAIL anode_set: got %b expected 1", anodeError); end
        vectors++; if (fv_count - f0 !== 0) begin miscompares++; $display("FAIL anode_no_capture: got %0d pulses expected 0", fv_count - f0); end
        drive_digit(0, sv(0, 0), 6);
        blank(4);
        vectors++; if (fv_count - f0 !== 1) begin miscompares++; $display("FAIL anode_then_frame: got %0d pulses expected 1", fv_count - f0); end
        vectors++; if (digits !== 16'h3210) begin miscompares++; $display("FAIL anode_frame_digits: got %h expected %h", digits, 16'h3210); end
        vectors++; if (anodeError !== 1'b1) begin miscompares++; $display("FAIL anode_sticky: got %b expected 1", anodeError); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (anodeError !== 1'b0) begin miscompares++; $display("FAIL anode_cleared_by_reset: got %b expected 0", anodeError); end
        @(negedge clk);
        rst_n = 1'b1;
        blank(2);
    endtask

    task automatic test_reset_midframe;
        int f0;
        scan_frame(8'b00000010, 8'b01010101, sv(2, 0), sv(3, 0));
        vectors++; if (digits !== 16'h32F0) begin miscompares++; $display("FAIL pre_rst_digits: got %h expected %h", digits, 16'h32F0); end
        vectors++; if (points !== 4'b0001) begin miscompares++; $display("FAIL pre_rst_points: got %b expected 0001", points); end
        vectors++; if (codeError !== 1'b1) begin miscompares++; $display("FAIL pre_rst_codeError: got %b expected 1", codeError); end
        drive_digit(0, sv(9, 0), 6);
        drive_digit(1, sv(8, 0), 6);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (digits !== 16'hFFFF) begin miscompares++; $display("FAIL midrst_digits: got %h expected %h", digits, 16'hFFFF); end
        vectors++; if (points !== 4'b0000) begin miscompares++; $display("FAIL midrst_points: got %b expected 0000", points); end
        vectors++; if (codeError !== 1'b0) begin miscompares++; $display("FAIL midrst_codeError: got %b expected 0", codeError); end
        vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL midrst_frameValid: got %b expected 0", frameValid); end
        @(negedge clk);
        rst_n = 1'b1;
        f0 = fv_count;
        drive_digit(2, sv(7, 0), 6);
        drive_digit(3, sv(6, 0), 6);
        blank(4);
        vectors++; if (fv_count - f0 !== 0) begin miscompares++; $display("FAIL midrst_partial: got %0d pulses expected 0", fv_count - f0); end
        vectors++; if (digits !== 16'hFFFF) begin miscompares++; $display("FAIL midrst_partial_digits: got %h expected %h", digits, 16'hFFFF); end
        drive_digit(0, sv(9, 0), 6);
        drive_digit(1, sv(8, 0), 6);
        blank(4);
        vectors++; if (fv_count - f0 !== 1) begin miscompares++; $display("FAIL midrst_full: got %0d pulses expected 1", fv_count - f0); end
        vectors++; if (digits !== 16'h6789) begin miscompares++; $display("FAIL midrst_full_digits: got %h expected %h", digits, 16'h6789); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_dash_point;
        test_short_dwell;
        test_bad_code;
        test_min_dwell;
        test_latency;
        test_anode_error;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
